// File: rtl/pipeline_pkg.sv
// ============================================================================
// Module  : pipeline_pkg
// Brief   : Shared types and constants for the RV32 fetch / IF-ID stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pipeline_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_skid_buf.sv
// ============================================================================
// Module  : fetch_skid_buf
// Brief   : One-entry {pc, instr} buffer for a response arriving under stall.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_skid_buf (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic        clear_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  output logic        full_o,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o
);

  logic        r_full;
  logic [31:0] r_pc;
  logic [31:0] r_instr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_full  <= 1'b0;
      r_pc    <= 32'd0;
      r_instr <= 32'd0;
    end else if (clear_i) begin
      r_full <= 1'b0;
    end else if (push_i) begin
      r_full  <= 1'b1;
      r_pc    <= pc_i;
      r_instr <= instr_i;
    end else if (pop_i) begin
      r_full <= 1'b0;
    end
  end

  assign full_o  = r_full;
  assign pc_o    = r_pc;
  assign instr_o = r_instr;

endmodule

`default_nettype wire

// File: rtl/if_id_stage.sv
// ============================================================================
// Module  : if_id_stage
// Brief   : Fetch FSM, fetch PC and IF/ID register; IF_PERF_EN adds counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        valid_o
`ifdef IF_PERF_EN
  ,
  output logic [31:0] perf_fetch_o,
  output logic [31:0] perf_kill_o
`endif
);

  import pipeline_pkg::*;

  fetch_state_t r_state;
  logic [31:0]  r_fetch_pc;
  logic [31:0]  r_req_pc;
  logic         r_kill;
  if_id_t       r_if_id;

  logic         w_rsp_take;
  logic         w_rsp_live;
  logic         w_load_new;
  logic         w_load_skid;
  logic         w_skid_push;
  logic         w_skid_clear;
  logic         w_skid_full;
  logic [31:0]  w_skid_pc;
  logic [31:0]  w_skid_instr;

  // A response is live only if neither a pending nor a same-cycle flush kills it.
  assign w_rsp_take   = (r_state == WAIT) && imem_rvalid_i;
  assign w_rsp_live   = w_rsp_take && !r_kill && !flush_i;
  assign w_load_new   = w_rsp_live && !stall_i;
  assign w_skid_push  = w_rsp_live && stall_i;
  assign w_load_skid  = (r_state == HOLD) && !stall_i && !flush_i;
  assign w_skid_clear = (r_state == HOLD) && flush_i;

  fetch_skid_buf u_skid (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_skid_push),
    .pop_i   (w_load_skid),
    .clear_i (w_skid_clear),
    .pc_i    (r_req_pc),
    .instr_i (imem_rdata_i),
    .full_o  (w_skid_full),
    .pc_o    (w_skid_pc),
    .instr_o (w_skid_instr)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= 32'd0;
      r_kill     <= 1'b0;
      r_if_id    <= '{pc: 32'd0, instr: NOP_INSTR, valid: 1'b0};
    end else begin
      case (r_state)
        IDLE: if (start_i) r_state <= REQ;
        REQ: begin
          if (imem_gnt_i) begin
            r_req_pc <= r_fetch_pc;
            r_state  <= WAIT;
            if (flush_i) r_kill <= 1'b1;
          end
        end
        WAIT: begin
          if (imem_rvalid_i) begin
            r_kill  <= 1'b0;
            r_state <= w_skid_push ? HOLD : REQ;
          end else if (flush_i) begin
            r_kill <= 1'b1;
          end
        end
        HOLD: if (flush_i || !stall_i) r_state <= REQ;
        default: r_state <= IDLE;
      endcase

      if (flush_i)
        r_fetch_pc <= word_align(branch_target_i);
      else if ((r_state == REQ) && imem_gnt_i)
        r_fetch_pc <= r_fetch_pc + PC_STEP;

      if (flush_i) begin
        r_if_id.instr <= NOP_INSTR;
        r_if_id.valid <= 1'b0;
      end else if (stall_i) begin
        r_if_id <= r_if_id;
      end else if (w_load_new) begin
        r_if_id <= '{pc: r_req_pc, instr: imem_rdata_i, valid: 1'b1};
      end else if (w_load_skid && w_skid_full) begin
        r_if_id <= '{pc: w_skid_pc, instr: w_skid_instr, valid: 1'b1};
      end else begin
        r_if_id.instr <= NOP_INSTR;
        r_if_id.valid <= 1'b0;
      end
    end
  end

  assign imem_req_o  = (r_state == REQ);
  assign imem_addr_o = r_fetch_pc;
  assign pc_o        = r_if_id.pc;
  assign instr_o     = r_if_id.instr;
  assign valid_o     = r_if_id.valid;

`ifdef IF_PERF_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_kill;
  logic [1:0]  w_kill_inc;

  assign w_kill_inc = {1'b0, (w_rsp_take && (r_kill || flush_i)) || w_skid_clear}
                    + {1'b0, flush_i && r_if_id.valid};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_perf_fetch <= 32'd0;
      r_perf_kill  <= 32'd0;
    end else begin
      if ((w_load_new || (w_load_skid && w_skid_full)) && (r_perf_fetch != 32'hFFFF_FFFF))
        r_perf_fetch <= r_perf_fetch + 32'd1;
      if (r_perf_kill > (32'hFFFF_FFFF - {30'd0, w_kill_inc}))
        r_perf_kill <= 32'hFFFF_FFFF;
      else
        r_perf_kill <= r_perf_kill + {30'd0, w_kill_inc};
    end
  end

  assign perf_fetch_o = r_perf_fetch;
  assign perf_kill_o  = r_perf_kill;
`else
  // Counters are absent in this build.
`endif

  // Late responses after reset land in IDLE and are tolerated.
  a_rvalid_in_wait: assert property (@(posedge clk_i) disable iff (rst_i)
    imem_rvalid_i |-> ((r_state == WAIT) || (r_state == IDLE)));

endmodule

`default_nettype wire

// File: tb/tb_if_id_stage.sv
// ============================================================================
// Module  : tb_if_id_stage
// Brief   : Directed self-checking bench for if_id_stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_id_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stall;
  logic        flush;
  logic [31:0] target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        valid;

  int n_vec = 0;
  int n_err = 0;

  if_id_stage dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .start_i         (start),
    .stall_i         (stall),
    .flush_i         (flush),
    .branch_target_i (target),
    .imem_req_o      (imem_req),
    .imem_addr_o     (imem_addr),
    .imem_gnt_i      (gnt),
    .imem_rvalid_i   (rvalid),
    .imem_rdata_i    (rdata),
    .pc_o            (pc),
    .instr_o         (instr),
    .valid_o         (valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0; flush = 1'b0;
    target = 32'd0; gnt = 1'b0; rvalid = 1'b0; rdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_instr", instr, NOP);
    chk("rst_pc", pc, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);

    // Straight-line fetch: gnt immediate, rvalid one cycle later
    rst = 1'b0; start = 1'b1; gnt = 1'b1;
    tick(); start = 1'b0;
    chk("t1_req0", {31'd0, imem_req}, 32'd1);
    chk("t1_addr0", imem_addr, 32'h0);
    tick();
    chk("t1_wait_req", {31'd0, imem_req}, 32'd0);
    rvalid = 1'b1; rdata = 32'h0010_0093;
    tick(); rvalid = 1'b0;
    chk("t1_valid0", {31'd0, valid}, 32'd1);
    chk("t1_pc0", pc, 32'h0);
    chk("t1_instr0", instr, 32'h0010_0093);
    chk("t1_addr4", imem_addr, 32'h4);
    tick();
    chk("t1_bubble_valid", {31'd0, valid}, 32'd0);
    chk("t1_bubble_instr", instr, NOP);
    rvalid = 1'b1; rdata = 32'h0020_0113;
    tick(); rvalid = 1'b0;
    chk("t1_pc4", pc, 32'h4);
    chk("t1_instr4", instr, 32'h0020_0113);
    chk("t1_addr8", imem_addr, 32'h8);
    tick();
    rvalid = 1'b1; rdata = 32'h0030_0193;
    tick(); rvalid = 1'b0;
    chk("t1_pc8", pc, 32'h8);
    chk("t1_valid8", {31'd0, valid}, 32'd1);

    // Stall while response arrives -> HOLD, then release
    stall = 1'b1;
    tick();
    chk("t2_held_instr", instr, 32'h0030_0193);
    rvalid = 1'b1; rdata = 32'h0050_0093;
    tick(); rvalid = 1'b0;
    chk("t2_hold_req", {31'd0, imem_req}, 32'd0);
    chk("t2_hold_instr", instr, 32'h0030_0193);
    tick();
    chk("t2_hold_req2", {31'd0, imem_req}, 32'd0);
    chk("t2_hold_valid", {31'd0, valid}, 32'd1);
    stall = 1'b0;
    tick();
    chk("t2_skid_instr", instr, 32'h0050_0093);
    chk("t2_skid_pc", pc, 32'hC);
    chk("t2_skid_valid", {31'd0, valid}, 32'd1);
    chk("t2_addr16", imem_addr, 32'h10);

    // Flush and stall together on a valid IF/ID entry
    flush = 1'b1; stall = 1'b1; target = 32'h200; gnt = 1'b0;
    tick(); flush = 1'b0; stall = 1'b0; gnt = 1'b1;
    chk("t4_instr", instr, NOP);
    chk("t4_valid", {31'd0, valid}, 32'd0);
    chk("t4_redirect", imem_addr, 32'h200);
    chk("t4_req", {31'd0, imem_req}, 32'd1);

    // Flush during WAIT: response killed, fetch resumes at aligned target
    tick();
    rvalid = 1'b1; rdata = 32'h0060_0213;
    tick(); rvalid = 1'b0;
    chk("t3_pre_pc", pc, 32'h200);
    stall = 1'b1;
    tick();
    chk("t3_wait_valid", {31'd0, valid}, 32'd1);
    stall = 1'b0; flush = 1'b1; target = 32'h103;
    tick(); flush = 1'b0;
    chk("t3_flush_valid", {31'd0, valid}, 32'd0);
    chk("t3_flush_instr", instr, NOP);
    chk("t3_still_wait", {31'd0, imem_req}, 32'd0);
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    tick(); rvalid = 1'b0;
    chk("t3_drop_valid", {31'd0, valid}, 32'd0);
    chk("t3_drop_instr", instr, NOP);
    chk("t3_req", {31'd0, imem_req}, 32'd1);
    chk("t3_addr", imem_addr, 32'h100);
    tick();
    rvalid = 1'b1; rdata = 32'h0070_0293;
    tick(); rvalid = 1'b0;
    chk("t3_pc", pc, 32'h100);
    chk("t3_instr", instr, 32'h0070_0293);

    // PC wrap at top of address space
    gnt = 1'b0; flush = 1'b1; target = 32'hFFFF_FFFF;
    tick(); flush = 1'b0; gnt = 1'b1;
    chk("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
    tick();
    rvalid = 1'b1; rdata = 32'h0080_0313;
    tick(); rvalid = 1'b0;
    chk("t5_pc_top", pc, 32'hFFFF_FFFC);
    chk("t5_addr_wrap", imem_addr, 32'h0);

    // Reset in WAIT, late response ignored, restart at RESET_PC
    tick();
    chk("t6_in_wait", {31'd0, imem_req}, 32'd0);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", {31'd0, valid}, 32'd0);
    chk("t6_rst_instr", instr, NOP);
    chk("t6_rst_pc", pc, 32'd0);
    chk("t6_rst_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    rst = 1'b0; rvalid = 1'b1; rdata = 32'h1234_5678;
    tick(); rvalid = 1'b0;
    chk("t6_late_valid", {31'd0, valid}, 32'd0);
    chk("t6_late_instr", instr, NOP);
    chk("t6_idle_req", {31'd0, imem_req}, 32'd0);
    start = 1'b1;
    tick(); start = 1'b0;
    chk("t6_restart_req", {31'd0, imem_req}, 32'd1);
    chk("t6_restart_addr", imem_addr, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
